// File: rtl/phy_mem_arb_pkg.sv
// Shared types and constants for the two-master physical memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package phy_mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD       = 2'd1,
        ST_WR_PULSE = 2'd2,
        ST_WR_WAIT  = 2'd3
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int RD_SETTLE_DEF  = 1;
    localparam int WR_TIMEOUT_DEF = 15;

    // Wide enough for both the read settle count (max 7) and the write timeout (max 15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/phy_mem_arbiter_if.sv
// Bundles both master request/response channels and the memory controller port.
// Latency: n/a (wiring only).
// Backpressure: masters hold req/we/addr/wdata until their one-cycle ack.
interface phy_mem_arbiter_if;

    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m0_rdata;
    logic        m0_ack;
    logic        m0_err;

    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [31:0] m1_rdata;
    logic        m1_ack;
    logic        m1_err;

    logic        mem_is_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_busy;

    logic        grant_id;
    logic        arb_busy;

    // Environment side: the two masters plus the memory controller.
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_data_out, mem_busy,
        input  m0_rdata, m0_ack, m0_err,
        input  m1_rdata, m1_ack, m1_err,
        input  mem_is_write, mem_addr, mem_data_in,
        input  grant_id, arb_busy
    );

    // Arbiter side.
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_data_out, mem_busy,
        output m0_rdata, m0_ack, m0_err,
        output m1_rdata, m1_ack, m1_err,
        output mem_is_write, mem_addr, mem_data_in,
        output grant_id, arb_busy
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Picks one of two masters, skipping any master masked out this cycle.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller consumes the grant only when it can start a transaction.
module rr_arbiter2
    import phy_mem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last_grant,
    output logic [1:0] grant
);

    logic [1:0] elig;

    assign elig = req & ~mask;

    // One-hot grant: a lone eligible master wins outright; a tie goes to master 0
    // under fixed priority, otherwise to whichever master was not served last.
    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
            if ((FIXED_PRIO != 0) || (last_grant == M1)) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end
    end

endmodule

// File: rtl/phy_mem_arbiter.sv
// Shares one physical memory controller port between two masters, one transaction at a time.
// Latency: read ack RD_SETTLE+1 cycles after accept; write ack >=4 cycles after accept, capped by WR_TIMEOUT.
// Backpressure: masters hold req until ack; mem_busy stretches writes, timeout acks with err=1.
module phy_mem_arbiter
    import phy_mem_arb_pkg::*;
#(
    parameter int RD_SETTLE  = RD_SETTLE_DEF,
    parameter int WR_TIMEOUT = WR_TIMEOUT_DEF,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk50M,
    input  logic             rst_n,
    phy_mem_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_SETTLE);
    localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_TIMEOUT);
    localparam logic [CNT_W-1:0] WR_FIRST2 = CNT_W'(2);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             grant_q;
    logic             mem_is_write_q;
    logic             arb_busy_q;
    logic [1:0]       ack_q;
    logic [1:0]       err_q;
    logic [31:0]      rdata0_q;
    logic [31:0]      rdata1_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_data_q;

    logic [1:0]       req_vec;
    logic [1:0]       grant;
    logic             win_id;
    logic             win_we;
    logic [31:0]      win_addr;
    logic [31:0]      win_wdata;

    assign req_vec = {bus.m1_req, bus.m0_req};

    // A master being acked right now still shows its old req; masking it with the
    // registered ack keeps that stale request from being served twice.
    rr_arbiter2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr_arbiter2 (
        .req        (req_vec),
        .mask       (ack_q),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign win_id    = grant[M1];
    assign win_we    = win_id ? bus.m1_we    : bus.m0_we;
    assign win_addr  = win_id ? bus.m1_addr  : bus.m0_addr;
    assign win_wdata = win_id ? bus.m1_wdata : bus.m0_wdata;

    // Transaction sequencer: accept, run the read or write handshake, then ack the owner.
    always_ff @(posedge clk50M) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            last_grant     <= M1;
            grant_q        <= M0;
            mem_is_write_q <= 1'b0;
            arb_busy_q     <= 1'b0;
            ack_q          <= 2'b00;
            err_q          <= 2'b00;
            rdata0_q       <= '0;
            rdata1_q       <= '0;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
        end else begin
            ack_q <= 2'b00;
            err_q <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        grant_q    <= win_id;
                        last_grant <= win_id;
                        mem_addr_q <= win_addr;
                        mem_data_q <= win_wdata;
                        arb_busy_q <= 1'b1;
                        cnt        <= CNT_W'(1);
                        if (win_we) begin
                            state          <= ST_WR_PULSE;
                            mem_is_write_q <= 1'b1;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (cnt == RD_LAST) begin
                        if (grant_q == M1) begin
                            rdata1_q <= bus.mem_data_out;
                        end else begin
                            rdata0_q <= bus.mem_data_out;
                        end
                        ack_q[grant_q] <= 1'b1;
                        arb_busy_q     <= 1'b0;
                        state          <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WR_PULSE: begin
                    mem_is_write_q <= 1'b0;
                    cnt            <= CNT_W'(1);
                    state          <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    // The controller may not have raised busy yet in the first wait cycle,
                    // so idle-looking busy only counts from the second cycle on.
                    if ((cnt >= WR_FIRST2) && !bus.mem_busy) begin
                        ack_q[grant_q] <= 1'b1;
                        arb_busy_q     <= 1'b0;
                        state          <= ST_IDLE;
                    end else if (cnt == WR_LAST) begin
                        ack_q[grant_q] <= 1'b1;
                        err_q[grant_q] <= 1'b1;
                        arb_busy_q     <= 1'b0;
                        state          <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.m0_ack       = ack_q[0];
    assign bus.m1_ack       = ack_q[1];
    assign bus.m0_err       = err_q[0];
    assign bus.m1_err       = err_q[1];
    assign bus.m0_rdata     = rdata0_q;
    assign bus.m1_rdata     = rdata1_q;
    assign bus.mem_is_write = mem_is_write_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_data_in  = mem_data_q;
    assign bus.grant_id     = grant_q;
    assign bus.arb_busy     = arb_busy_q;

endmodule
